// File: rtl/proc_out_serializer_pkg.sv
// Shared engine parameters, sideband type and the kernel-width keep-mask LUT.
// The engine and the output serializer both use this mask, so they agree on column semantics.
package proc_out_serializer_pkg;

  localparam int unsigned COLS     = 8;
  localparam int unsigned ROWS     = 4;
  localparam int unsigned Y_BITS   = 16;
  localparam int unsigned KW_MAX   = 5;
  localparam int unsigned COL_BITS = $clog2(COLS);
  localparam int unsigned KW2_BITS = $clog2(KW_MAX / 2 + 1);
  localparam int unsigned TAG_BITS = 4;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic                is_config;
    logic [KW2_BITS-1:0] kw2;
  } tuser_st;

  localparam int unsigned TUSER_WIDTH = $bits(tuser_st);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Column col survives when it is the last column of a kernel-width group of K = 2*kw2+1.
  function automatic logic keep_bit(input int unsigned kw2, input int unsigned col);
    return ((col + 1) % (2 * kw2 + 1)) == 0;
  endfunction

  function automatic logic [COLS-1:0] keep_mask(input logic [KW2_BITS-1:0] kw2);
    logic [COLS-1:0] mask;
    for (int unsigned c = 0; c < COLS; c++) begin
      mask[c] = keep_bit(32'(kw2), c);
    end
    return mask;
  endfunction

endpackage

// File: rtl/proc_out_serializer_col_priority_enc.sv
// Lowest-set-bit priority encoder over a column mask; purely combinational.
module col_priority_enc #(
  parameter int unsigned COLS     = 8,
  parameter int unsigned COL_BITS = $clog2(COLS)
) (
  input  logic [COLS-1:0]     mask,
  output logic [COL_BITS-1:0] idx,
  output logic [COLS-1:0]     onehot,
  output logic                is_single
);

  always_comb begin
    // Two's-complement isolates the lowest set bit without a ripple scan.
    onehot    = mask & (~mask + COLS'(1));
    is_single = (mask != '0) && ((mask & (mask - COLS'(1))) == '0);
    idx       = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (onehot[c]) begin
        idx = idx | COL_BITS'(c);
      end
    end
  end

endmodule

// File: rtl/proc_out_serializer.sv
// Serializes one wide COLSxROWS partial-sum beat into ROWS-wide column beats,
// emitting only the columns kept by the kernel-width group mask.
module proc_out_serializer #(
  parameter int unsigned COLS     = proc_out_serializer_pkg::COLS,
  parameter int unsigned ROWS     = proc_out_serializer_pkg::ROWS,
  parameter int unsigned Y_BITS   = proc_out_serializer_pkg::Y_BITS,
  parameter int unsigned KW_MAX   = proc_out_serializer_pkg::KW_MAX,
  parameter int unsigned COL_BITS = $clog2(COLS)
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  output logic                                   s_ready,
  input  logic                                   s_valid,
  input  logic                                   s_last,
  input  logic [COLS-1:0][ROWS-1:0][Y_BITS-1:0]  s_data,
  input  proc_out_serializer_pkg::tuser_st       s_user,
  input  logic                                   m_ready,
  output logic                                   m_valid,
  output logic                                   m_last,
  output logic [ROWS-1:0][Y_BITS-1:0]            m_data,
  output logic [COL_BITS-1:0]                    m_col,
  output proc_out_serializer_pkg::tuser_st       m_user
);

  import proc_out_serializer_pkg::*;

  if (2 * (KW_MAX / 2) + 1 > COLS) begin : g_kw_check
    $error("KW_MAX kernel group does not fit in COLS columns");
  end

  localparam int unsigned KW2_VALS = 1 << KW2_BITS;

  state_e state_q, state_d;

  logic [COLS-1:0][ROWS-1:0][Y_BITS-1:0] hold_data_q;
  tuser_st                               hold_user_q;
  logic                                  hold_last_q;
  logic [COLS-1:0]                       mask_q;

  logic [COLS-1:0]     keep_lut [KW2_VALS];
  logic [COLS-1:0]     keep_in;
  logic [COL_BITS-1:0] col_idx;
  logic [COLS-1:0]     col_onehot;
  logic                is_single;
  logic                s_hs;
  logic                m_hs;
  logic                load;

  for (genvar k = 0; k < KW2_VALS; k++) begin : g_lut
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign keep_lut[k][c] = keep_bit(k, c);
    end
  end

  col_priority_enc #(
    .COLS     (COLS),
    .COL_BITS (COL_BITS)
  ) u_enc (
    .mask      (mask_q),
    .idx       (col_idx),
    .onehot    (col_onehot),
    .is_single (is_single)
  );

  assign keep_in = keep_lut[s_user.kw2];
  assign s_hs    = s_valid & s_ready;
  assign m_hs    = m_valid & m_ready;
  // An empty keep mask cannot yield output, so such a beat is dropped like a config beat.
  assign load    = s_hs & ~s_user.is_config & (keep_in != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (m_ready && is_single) begin
          state_d = load ? StShift : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_valid = (state_q == StShift);
    s_ready = (state_q == StIdle) | (is_single & m_ready);
    m_last  = hold_last_q & is_single;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_data_q <= '0;
      hold_user_q <= '0;
      hold_last_q <= 1'b0;
      mask_q      <= '0;
    end else if (load) begin
      hold_data_q <= s_data;
      hold_user_q <= s_user;
      hold_last_q <= s_last;
      mask_q      <= keep_in;
    end else if (m_hs) begin
      mask_q <= mask_q & ~col_onehot;
    end
  end

  assign m_data = hold_data_q[col_idx];
  assign m_col  = col_idx;
  assign m_user = hold_user_q;

endmodule

// File: tb/tb_proc_out_serializer.sv
// Scoreboard bench for proc_out_serializer: expected column beats are queued on wide-beat
// acceptance and compared on each column handshake.
module tb_proc_out_serializer;
  import proc_out_serializer_pkg::*;

  typedef struct {
    logic [COL_BITS-1:0]       col;
    logic [ROWS*Y_BITS-1:0]    data;
    tuser_st                   user;
    logic                      last;
    logic                      fin;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic s_ready, s_valid, s_last;
  logic [COLS-1:0][ROWS-1:0][Y_BITS-1:0] s_data;
  tuser_st s_user;
  logic m_ready = 1'b1;
  logic m_valid, m_last;
  logic [ROWS-1:0][Y_BITS-1:0] m_data;
  logic [COL_BITS-1:0] m_col;
  tuser_st m_user;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   last_cnt = 0;
  int   hs_first_cyc = 0;
  int   hs_last_cyc = 0;
  int   hs_first_col = 0;
  int   tag_cnt = 0;
  bit   rand_ready = 1'b0;

  proc_out_serializer u_dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_ready (s_ready),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_user  (s_user),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_data  (m_data),
    .m_col   (m_col),
    .m_user  (m_user)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard compare, s_ready expectation and AXI hold rule.
  logic                   prev_stall = 1'b0;
  logic [ROWS*Y_BITS-1:0] prev_data;
  logic [COL_BITS-1:0]    prev_col;
  logic                   prev_last;
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_col", m_col, prev_col);
        check("hold_last", m_last, prev_last);
      end
      if (!m_valid) exp_rdy = 1'b1;
      else if (sb.size() > 0) exp_rdy = m_ready && sb[0].fin;
      else exp_rdy = m_ready;
      check("s_ready", s_ready, exp_rdy);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("spurious_beat", m_valid, 0);
        end else begin
          e = sb.pop_front();
          check("m_col", m_col, e.col);
          check("m_data", m_data, e.data);
          check("m_user", m_user, e.user);
          check("m_last", m_last, e.last);
          if (hs_cnt == 0) begin
            hs_first_cyc = cyc;
            hs_first_col = int'(m_col);
          end
          hs_last_cyc = cyc;
          hs_cnt++;
          if (m_last) last_cnt++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_col   = m_col;
      prev_last  = m_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_hs();
    hs_cnt   = 0;
    last_cnt = 0;
  endtask

  // Called and returns at posedge+1; holds the beat until accepted.
  task automatic send_beat(input int kw2, input bit cfg, input bit last, input int base);
    int hi;
    int k;
    exp_t e;
    for (int c = 0; c < int'(COLS); c++) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        s_data[c][r] = Y_BITS'(base + 16 * c + r);
      end
    end
    s_user.tag       = TAG_BITS'(tag_cnt);
    s_user.is_config = cfg;
    s_user.kw2       = KW2_BITS'(kw2);
    s_last           = last;
    s_valid          = 1'b1;
    tag_cnt++;
    k  = 2 * kw2 + 1;
    hi = -1;
    for (int c = 0; c < int'(COLS); c++) if ((c + 1) % k == 0) hi = c;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (s_ready) begin
        if (!cfg) begin
          for (int c = 0; c < int'(COLS); c++) begin
            if ((c + 1) % k == 0) begin
              e.col  = COL_BITS'(c);
              e.data = s_data[c];
              e.user = s_user;
              e.fin  = (c == hi);
              e.last = last && (c == hi);
              sb.push_back(e);
            end
          end
        end
        @(posedge clk);
        #1;
        break;
      end
      if (n >= 300) begin
        check("accept_timeout", s_ready, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !m_valid;
      @(posedge clk);
      #1;
      if (done) break;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    s_user  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_col", m_col, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_user", m_user, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // 1: kw2=0, all columns, no gaps, m_last on column 7.
    reset_hs();
    send_beat(0, 1'b0, 1'b1, 0);
    wait_drain();
    check("t1_count", hs_cnt, 8);
    check("t1_gapless", hs_last_cyc - hs_first_cyc, 7);
    check("t1_last_count", last_cnt, 1);

    // 2: kw2=1 back-to-back, columns 2,5,2,5 gap-free.
    reset_hs();
    send_beat(1, 1'b0, 1'b0, 'h100);
    send_beat(1, 1'b0, 1'b1, 'h200);
    wait_drain();
    check("t2_count", hs_cnt, 4);
    check("t2_gapless", hs_last_cyc - hs_first_cyc, 3);

    // 3: config beat between two kw2=0 beats.
    reset_hs();
    send_beat(0, 1'b0, 1'b0, 'h300);
    wait_drain();
    @(negedge clk);
    check("t3_ready_pre_cfg", s_ready, 1);
    @(posedge clk);
    #1;
    send_beat(0, 1'b1, 1'b1, 'h7700);
    @(negedge clk);
    check("t3_cfg_no_out", m_valid, 0);
    check("t3_ready_post_cfg", s_ready, 1);
    @(posedge clk);
    #1;
    send_beat(0, 1'b0, 1'b1, 'h400);
    wait_drain();
    check("t3_count", hs_cnt, 16);

    // 4: kw2=2 with random backpressure, column 4 only.
    rand_ready = 1'b1;
    reset_hs();
    for (int i = 0; i < 4; i++) send_beat(2, 1'b0, (i == 3), 'h500 + 'h40 * i);
    wait_drain();
    check("t4_count", hs_cnt, 4);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // 5: reset after the first of 8 columns.
    reset_hs();
    send_beat(0, 1'b0, 1'b1, 'h600);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    sb.delete();
    @(negedge clk);
    check("t5_valid_low", m_valid, 0);
    check("t5_ready_high", s_ready, 1);
    check("t5_col_zero", m_col, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_leftover", hs_cnt, 1);
    reset_hs();
    send_beat(0, 1'b0, 1'b1, 'h700);
    wait_drain();
    check("t5_next_count", hs_cnt, 8);
    check("t5_next_first_col", hs_first_col, 0);

    // 6: s_last=0 then s_last=1 with kw2=1.
    reset_hs();
    send_beat(1, 1'b0, 1'b0, 'h800);
    send_beat(1, 1'b0, 1'b1, 'h900);
    wait_drain();
    check("t6_count", hs_cnt, 4);
    check("t6_last_count", last_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/proc_out_serializer.md
Name: proc_out_serializer

Overview:
- Sits directly downstream of the convolution engine's output skid register.
- Accepts one wide AXI-Stream beat of COLS×ROWS partial-sum words. Emits the valid output columns one per beat as a ROWS-wide stream to the output pipeline (bias/activation/pack).
- Column selection follows the kernel-width group structure carried in tuser. Config beats are absorbed and produce no output.

Parameters:
- COLS, `COLS, number of engine columns (output channels per wide beat).
- ROWS, `ROWS, number of engine rows (pixels per column).
- Y_BITS, `Y_BITS, width of one accumulated word.
- KW_MAX, `KW_MAX, maximum kernel width; 2*(KW_MAX/2)+1 <= COLS is required, and a compile-time assertion enforces it.
- COL_BITS, $clog2(COLS), width of the column index.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- s_ready  out  1  wide-beat ready
- s_valid  in  1  wide-beat valid
- s_last  in  1  last wide beat of tensor
- s_data  in  COLS*ROWS*Y_BITS  packed [COLS][ROWS][Y_BITS]
- s_user  in  tuser_st  engine sideband (kw2, is_config, ...)
- m_ready  in  1  column-beat ready
- m_valid  out  1  column-beat valid
- m_last  out  1  last column of last wide beat
- m_data  out  ROWS*Y_BITS  packed [ROWS][Y_BITS], one column
- m_col  out  COL_BITS  source column index of m_data
- m_user  out  tuser_st  s_user of the source wide beat, held

Behaviour:
- Reset values:
  - Synchronous reset: when resetn is low at a clk edge, m_valid=0, m_last=0, m_col=0, m_data=0, m_user=0, and the state goes to IDLE.
  - s_ready=1 in the cycle after reset.
  - Reset mid-burst discards all held columns; no partial output follows reset.
- Keep mask:
  - K = 2*s_user.kw2+1.
  - keep[c] = ((c+1) % K == 0), computed from a constant LUT indexed by kw2.
  - kw2=0 keeps all columns. kw2=1 with COLS=8 keeps columns 2 and 5.
- Config beats: a beat with s_user.is_config=1 is accepted (s_ready rules apply) and dropped. The state is unchanged and nothing is emitted.
- Capture: on s_valid&s_ready with a non-config beat, register s_data, s_user, s_last and keep into the holding register, then enter SHIFT.
- States:
  - IDLE:
    - s_ready=1, m_valid=0.
    - A non-config accept moves to SHIFT.
    - m_valid rises the cycle after acceptance (latency 1).
  - SHIFT:
    - m_valid=1 and m_data = the held column at index = lowest set bit of the remaining mask.
    - On m_ready the bit is cleared and the next set bit is presented in the following cycle. There are no bubbles; a priority encoder is used, not a linear scan.
- Last column of a beat:
  - m_last = held s_last AND this is the highest set bit.
  - s_ready = (state==IDLE) | (remaining mask has exactly one bit & m_ready).
- Back-to-back:
  - A simultaneous final-column handshake and new accept reloads the holding register with zero idle cycles, so throughput is popcount(keep) cycles per wide beat.
  - A simultaneous final-column handshake and config-beat accept transitions to IDLE.
  - A final-column handshake with no accept transitions to IDLE.
- Output hold: m_data, m_col, m_user and m_last are stable while m_valid & !m_ready (AXI-Stream rule).
- No arithmetic is performed: data passes bit-exact.

Decomposition:
- The shared params package/header supplies COLS, ROWS, Y_BITS, KW_MAX, TUSER_WIDTH and tuser_st. The keep-mask LUT function (kw2 -> COLS-bit mask) is added there so the engine and this block agree on column semantics.
- One sub-module, col_priority_enc: COLS-bit mask -> first-set index, onehot, and is_single flag; purely combinational.

Test Plan:
1. COLS=8, kw2=0, one beat with s_last=1 and word(c,r)=16c+r, m_ready=1 -> 8 beats with m_col 0..7 in consecutive cycles, m_data[r]=16c+r, m_last only at m_col=7.
2. kw2=1, two back-to-back beats with s_valid held high -> output m_col sequence 2,5,2,5 with no gap cycles; s_ready is high exactly in the cycles of the m_col=5 handshakes.
3. Config beat (is_config=1) between two kw2=0 beats -> 16 outputs total and no output carrying the config payload; s_ready stays 1 through the config beat.
4. Random m_ready (~50%), kw2=2 -> m_data/m_col/m_last stable during stalls; keep equals (c+1)%5==0, so COLS=8 gives column 4 only, one beat per wide beat.
5. resetn low for 1 cycle during SHIFT after the first of 8 columns -> m_valid=0 next cycle, s_ready=1, no remaining columns emitted; the next beat is serialized from m_col=0.
6. Beat with s_last=0 followed by a beat with s_last=1, kw2=1 -> m_last asserted only on the second beat's m_col=5.
